// File: rtl/mode_switch_pkg.sv
// Shared types and 7-segment constants for the mode selector.
// Latency: none; declarations only.
// Backpressure: not applicable.
package mode_switch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEADTIME = 2'd1,
        ACTIVE   = 2'd2
    } state_e;

    // Common-anode, active-low segments, bit7 = dp (always off).
    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };
    localparam logic [7:0] SEG_FAULT      = 8'h86;
    localparam logic [7:0] SEG_BLANK_ZERO = 8'hC0;

    // Mode i is shown to the driver as digit i+1; anything beyond 8 has no digit.
    function automatic logic [7:0] seg_for_mode(input logic [3:0] mode);
        logic [7:0] seg;
        seg = SEG_FAULT;
        if (mode < 4'd9) begin
            seg = SEG_DIGIT[mode + 4'd1];
        end
        return seg;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus whole-vector debounce of the raw mode switches.
// Latency: a step held from edge t appears on sw_db at edge t+2+CYCLES.
// Backpressure: none; free-running, any change restarts the stability count.
module sw_debounce #(
    parameter int WIDTH  = 5,
    parameter int CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db
);

    localparam int            CW       = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(CYCLES);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] db_q,   db_d;
    logic [CW-1:0]    cnt_q,  cnt_d;

    // Count how long the synchronised vector has held a value that differs from
    // the accepted one; cand tracks that value so a change restarts the count.
    always_comb begin
        meta_d = sw;
        sync_d = meta_q;
        cand_d = cand_q;
        db_d   = db_q;
        cnt_d  = cnt_q;
        if (sync_q == db_q) begin
            cnt_d  = '0;
            cand_d = sync_q;
        end else if (sync_q != cand_q) begin
            cnt_d  = CW'(1);
            cand_d = sync_q;
        end else if (cnt_q == CNT_DONE) begin
            db_d  = sync_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            cand_q <= '0;
            db_q   <= '0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            cand_q <= cand_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sw_db = db_q;

endmodule

// File: rtl/mode_switch_ctrl.sv
// Debounced one-hot mode selector with break-before-make dead time and 7-seg status.
// Latency: enable asserts DEBOUNCE_CYCLES+2+1+DEADTIME_CYCLES edges after a switch step.
// Backpressure: none; every mode change forces an all-off dead time first.
module mode_switch_ctrl
    import mode_switch_pkg::*;
#(
    parameter int NUM_MODES       = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEADTIME_CYCLES = 50000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_MODES-1:0] SW,
    output logic [NUM_MODES-1:0] EN_N,
    output logic [7:0]           SEG,
    output logic                 DIG,
    output logic                 MODE_VALID,
    output logic                 FAULT
);

    localparam int             DTW     = $clog2(DEADTIME_CYCLES + 1);
    localparam logic [DTW-1:0] DT_LAST = DTW'(DEADTIME_CYCLES - 1);

    logic [NUM_MODES-1:0] sw_db;
    logic [3:0]           ones;
    logic [3:0]           req_idx;
    logic                 req_vld;
    logic                 req_multi;

    state_e               state_q,  state_d;
    logic [3:0]           target_q, target_d;
    logic [DTW-1:0]       dt_cnt_q, dt_cnt_d;
    logic [NUM_MODES-1:0] en_n_q,   en_n_d;
    logic [7:0]           seg_q,    seg_d;
    logic                 mv_q,     mv_d;
    logic                 fault_q,  fault_d;

    sw_debounce #(
        .WIDTH  (NUM_MODES),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk   (CLK),
        .rst   (RST),
        .sw    (SW),
        .sw_db (sw_db)
    );

    // Classify the debounced vector: single switch, none, or several (fault).
    always_comb begin
        ones    = '0;
        req_idx = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (sw_db[i]) begin
                ones    = ones + 4'd1;
                req_idx = 4'(i);
            end
        end
        req_vld   = (ones == 4'd1);
        req_multi = (ones > 4'd1);
    end

    // Next state and next registered outputs; enables only ever drop on a mode change.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dt_cnt_d = dt_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    state_d  = DEADTIME;
                    target_d = req_idx;
                    dt_cnt_d = '0;
                end
            end
            DEADTIME: begin
                if (!req_vld) begin
                    state_d = IDLE;
                end else if (req_idx != target_q) begin
                    target_d = req_idx;
                    dt_cnt_d = '0;
                end else if (dt_cnt_q == DT_LAST) begin
                    state_d = ACTIVE;
                end else begin
                    dt_cnt_d = dt_cnt_q + DTW'(1);
                end
            end
            ACTIVE: begin
                if (!req_vld) begin
                    state_d = IDLE;
                end else if (req_idx != target_q) begin
                    state_d  = DEADTIME;
                    target_d = req_idx;
                    dt_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        fault_d = req_multi;
        mv_d    = (state_d == ACTIVE);
        for (int i = 0; i < NUM_MODES; i++) begin
            en_n_d[i] = !((state_d == ACTIVE) && (target_d == 4'(i)));
        end
        if (state_d == IDLE) begin
            seg_d = fault_d ? SEG_FAULT : SEG_BLANK_ZERO;
        end else begin
            seg_d = seg_for_mode(target_d);
        end
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            target_q <= '0;
            dt_cnt_q <= '0;
            en_n_q   <= '1;
            seg_q    <= SEG_BLANK_ZERO;
            mv_q     <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            dt_cnt_q <= dt_cnt_d;
            en_n_q   <= en_n_d;
            seg_q    <= seg_d;
            mv_q     <= mv_d;
            fault_q  <= fault_d;
        end
    end

    assign EN_N       = en_n_q;
    assign SEG        = seg_q;
    assign DIG        = 1'b0;
    assign MODE_VALID = mv_q;
    assign FAULT      = fault_q;

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Bench for mode_switch_ctrl: per-cycle reference model plus directed literal checks.
// Latency: model follows the switch-to-enable timing edge by edge.
// Backpressure: not applicable.
module tb_mode_switch_ctrl;

    localparam int NM = 5;
    localparam int DB = 4;
    localparam int DT = 3;
    localparam logic [7:0] DIGITS [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [NM-1:0] SW  = '0;
    logic [NM-1:0] EN_N;
    logic [7:0]    SEG;
    logic          DIG;
    logic          MODE_VALID;
    logic          FAULT;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mode_switch_ctrl #(
        .NUM_MODES       (NM),
        .DEBOUNCE_CYCLES (DB),
        .DEADTIME_CYCLES (DT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SW         (SW),
        .EN_N       (EN_N),
        .SEG        (SEG),
        .DIG        (DIG),
        .MODE_VALID (MODE_VALID),
        .FAULT      (FAULT)
    );

    function automatic int popc(input logic [NM-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NM; i++) if (v[i]) n++;
        return n;
    endfunction

    function automatic int bit_idx(input logic [NM-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NM; i++) if (v[i]) n = i;
        return n;
    endfunction

    // Reference model: SW samples per edge; accepted vector changes once the
    // last DB+1 synchronised samples agree; an enable is on once the same
    // single request has been seen for DT+1 consecutive edges.
    logic [NM-1:0] m_samp [0:DB+1];
    logic [NM-1:0] m_db;
    int            m_run;
    int            m_mode;
    int            m_n1;
    bit            m_stab;
    bit            chk_en = 1'b0;
    logic [NM-1:0] x_en_n;
    logic [7:0]    x_seg;
    logic          x_mv;
    logic          x_fault;

    always @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k <= DB + 1; k++) m_samp[k] = '0;
            m_db    = '0;
            m_run   = 0;
            m_mode  = 0;
            x_en_n  = '1;
            x_seg   = 8'hC0;
            x_mv    = 1'b0;
            x_fault = 1'b0;
            chk_en  = 1'b1;
        end else begin
            m_n1 = popc(m_db);
            if (m_n1 == 1) begin
                if (m_run > 0 && bit_idx(m_db) == m_mode) begin
                    m_run++;
                end else begin
                    m_run  = 1;
                    m_mode = bit_idx(m_db);
                end
            end else begin
                m_run = 0;
            end
            x_fault = (m_n1 > 1);
            x_mv    = (m_run >= DT + 1);
            x_en_n  = '1;
            if (x_mv) x_en_n[m_mode] = 1'b0;
            if (m_run > 0) x_seg = DIGITS[m_mode + 1];
            else           x_seg = x_fault ? 8'h86 : 8'hC0;

            m_stab = 1'b1;
            for (int k = 2; k <= DB + 1; k++) if (m_samp[k] !== m_samp[1]) m_stab = 1'b0;
            if (m_stab && (m_samp[1] !== m_db)) m_db = m_samp[1];
            for (int k = DB + 1; k > 0; k--) m_samp[k] = m_samp[k-1];
            m_samp[0] = SW;
        end
    end

    // Every cycle after the first reset edge: DUT outputs against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            total++;
            if ({EN_N, SEG, DIG, MODE_VALID, FAULT} !== {x_en_n, x_seg, 1'b0, x_mv, x_fault}) begin
                bad++;
                $display("FAIL cycle_model @%0t: got en_n=%b seg=%h dig=%b mv=%b fault=%b, want en_n=%b seg=%h dig=0 mv=%b fault=%b",
                         $time, EN_N, SEG, DIG, MODE_VALID, FAULT, x_en_n, x_seg, x_mv, x_fault);
            end
            total++;
            if (popc(~EN_N) > 1) begin
                bad++;
                $display("FAIL break_before_make @%0t: en_n=%b has more than one low bit", $time, EN_N);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    initial begin
        // 1: reset and idle
        RST = 1'b1;
        SW  = '0;
        step(3);
        chk("reset_en_n", 32'(EN_N), 32'h1F);
        chk("reset_seg",  32'(SEG),  32'hC0);
        RST = 1'b0;
        step(20);
        chk("idle_en_n",  32'(EN_N),       32'h1F);
        chk("idle_seg",   32'(SEG),        32'hC0);
        chk("idle_mv",    32'(MODE_VALID), 32'h0);
        chk("idle_fault", 32'(FAULT),      32'h0);
        chk("idle_dig",   32'(DIG),        32'h0);

        // 2: mode 2 from idle; step sampled at edge t
        SW = 5'b00100;
        step(1);                         // t
        step(9);                         // t+9
        chk("m2_dead_en_n", 32'(EN_N),       32'h1F);
        chk("m2_dead_mv",   32'(MODE_VALID), 32'h0);
        step(1);                         // t+10
        chk("m2_en_n",     32'(EN_N),       32'h1B);
        chk("m2_seg",      32'(SEG),        32'hB0);
        chk("m2_mv",       32'(MODE_VALID), 32'h1);
        chk("model_m2_en", 32'(x_en_n),     32'h1B);

        // 3: switch 2 -> 4, break before make
        step(5);
        SW = 5'b10000;
        step(1);                         // u
        step(6);                         // u+6: new vector just accepted
        chk("sw4_hold_en_n", 32'(EN_N), 32'h1B);
        step(1);                         // u+7
        chk("sw4_break_en_n", 32'(EN_N),       32'h1F);
        chk("sw4_break_mv",   32'(MODE_VALID), 32'h0);
        step(2);                         // u+9
        chk("sw4_dead_en_n", 32'(EN_N), 32'h1F);
        step(1);                         // u+10
        chk("m4_en_n", 32'(EN_N), 32'h0F);
        chk("m4_seg",  32'(SEG),  32'h92);

        // back to idle
        SW = '0;
        step(12);
        chk("off_en_n", 32'(EN_N),       32'h1F);
        chk("off_seg",  32'(SEG),        32'hC0);
        chk("off_mv",   32'(MODE_VALID), 32'h0);

        // 4: three-cycle glitch is rejected
        SW = 5'b00001;
        step(3);
        SW = '0;
        step(15);
        chk("glitch_en_n", 32'(EN_N), 32'h1F);
        chk("glitch_seg",  32'(SEG),  32'hC0);

        // 5: two switches -> fault, then clean mode 1
        SW = 5'b00011;
        step(1);                         // f
        step(7);                         // f+7
        chk("fault_flag", 32'(FAULT), 32'h1);
        chk("fault_seg",  32'(SEG),   32'h86);
        chk("fault_en_n", 32'(EN_N),  32'h1F);
        chk("model_fault_seg", 32'(x_seg), 32'h86);
        SW = 5'b00010;
        step(1);                         // v
        step(7);                         // v+7
        chk("unfault_flag", 32'(FAULT), 32'h0);
        step(2);                         // v+9
        chk("m1_dead_en_n", 32'(EN_N), 32'h1F);
        step(1);                         // v+10
        chk("m1_en_n", 32'(EN_N),       32'h1D);
        chk("m1_seg",  32'(SEG),        32'hA4);
        chk("m1_mv",   32'(MODE_VALID), 32'h1);

        // 6: mode 0 active, then a one-cycle reset
        SW = 5'b00001;
        step(1);                         // w
        step(10);                        // w+10
        chk("m0_en_n", 32'(EN_N), 32'h1E);
        chk("m0_seg",  32'(SEG),  32'hF9);
        RST = 1'b1;
        step(1);                         // r
        chk("rst_mid_en_n", 32'(EN_N),       32'h1F);
        chk("rst_mid_seg",  32'(SEG),        32'hC0);
        chk("rst_mid_mv",   32'(MODE_VALID), 32'h0);
        RST = 1'b0;
        step(10);                        // r+10
        chk("rearm_dead_en_n", 32'(EN_N), 32'h1F);
        step(1);                         // r+11
        chk("rearm_en_n", 32'(EN_N), 32'h1E);
        chk("rearm_seg",  32'(SEG),  32'hF9);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
